// File: rtl/dcache_pkg.sv
// Shared sizing and line record for the direct-mapped data cache.
package dcache_pkg;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_LINES     = 16;
  localparam int DEF_MEM_WORDS = 1024;

  localparam int IDX_W = $clog2(DEF_LINES);
  localparam int TAG_W = $clog2(DEF_MEM_WORDS) - IDX_W;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic [DEF_DATA_W-1:0] data;
  } line_t;
endpackage

// File: rtl/dcache_mem.sv
// Word-addressed backing RAM: synchronous write, combinational read.
module dcache_mem #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 1024,
  parameter int AW     = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, write-allocate one-word-per-line data cache
// with an internal backing memory; misses are filled in the same cycle.
module data_cache
  import dcache_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LINES     = DEF_LINES,
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write,
  input  logic              read,
  output logic [DATA_W-1:0] temp_out,
  output logic              hit
);
  localparam int AW = IDX_W + TAG_W;

  // The line record is sized by the package, so the instance must match it.
  if (DATA_W != DEF_DATA_W || LINES != DEF_LINES || MEM_WORDS != DEF_MEM_WORDS) begin : g_bad_cfg
    $error("data_cache parameters must match dcache_pkg defaults");
  end

  line_t             lines_q [LINES];
  line_t             line_d, cur;
  logic              line_we, line_hit;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] temp_out_q, temp_out_d;
  logic              hit_q, hit_d;
  logic              unused_addr;

  assign idx         = address[IDX_W-1:0];
  assign tag         = address[AW-1:IDX_W];
  assign unused_addr = ^address[31:AW];

  dcache_mem #(.DATA_W(DATA_W), .WORDS(MEM_WORDS)) u_mem (
    .clk   (clk),
    .we    (write),
    .addr  (address[AW-1:0]),
    .wdata (data_in),
    .rdata (mem_rdata)
  );

  always_comb begin
    cur        = lines_q[idx];
    line_hit   = cur.valid && (cur.tag == tag);
    temp_out_d = temp_out_q;
    hit_d      = hit_q;
    line_we    = 1'b0;
    line_d     = '{valid: 1'b1, tag: tag, data: data_in};
    if (write) begin
      line_we = 1'b1;
    end else if (read) begin
      if (line_hit) begin
        temp_out_d = cur.data;
        hit_d      = 1'b1;
      end else begin
        // Fill from memory, which always holds current data.
        temp_out_d  = mem_rdata;
        hit_d       = 1'b0;
        line_we     = 1'b1;
        line_d.data = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      temp_out_q <= '0;
      hit_q      <= 1'b0;
      for (int i = 0; i < LINES; i++) lines_q[i].valid <= 1'b0;
    end else begin
      temp_out_q <= temp_out_d;
      hit_q      <= hit_d;
      if (line_we) lines_q[idx] <= line_d;
    end
  end

  assign temp_out = temp_out_q;
  assign hit      = hit_q;
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a memory/residency model checked every cycle
// plus hand-computed literal expectations along the test sequence.
module tb_data_cache;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic        write = 1'b0;
  logic        read  = 1'b0;
  logic [31:0] temp_out;
  logic        hit;

  int n_chk  = 0;
  int n_pass = 0;

  data_cache dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .data_in  (data_in),
    .write    (write),
    .read     (read),
    .temp_out (temp_out),
    .hit      (hit)
  );

  always #5 clk = ~clk;

  // Model: memory contents plus which full word address each index holds.
  logic [31:0] mem_m [1024];
  bit          res_v [16];
  logic [9:0]  res_a [16];
  logic [31:0] exp_temp;
  logic        exp_hit;

  always @(posedge clk or negedge rst) begin
    logic [9:0] a;
    if (!rst) begin
      foreach (res_v[i]) res_v[i] = 1'b0;
      exp_temp = '0;
      exp_hit  = 1'b0;
    end else begin
      a = address[9:0];
      if (write) begin
        mem_m[a]       = data_in;
        res_v[a % 16]  = 1'b1;
        res_a[a % 16]  = a;
      end else if (read) begin
        exp_hit        = res_v[a % 16] && (res_a[a % 16] == a);
        exp_temp       = mem_m[a];
        res_v[a % 16]  = 1'b1;
        res_a[a % 16]  = a;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("model temp_out", temp_out, exp_temp);
      check("model hit", {31'b0, hit}, {31'b0, exp_hit});
    end
  end

  task automatic op(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    write = wr; read = rd; address = a; data_in = d;
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] t, input logic h);
    check({name, " temp_out"}, temp_out, t);
    check({name, " hit"}, {31'b0, hit}, {31'b0, h});
  endtask

  initial begin
    #12;
    expect_out("reset", 32'd0, 1'b0);
    rst = 1'b1;

    op(1, 0, 10, 54);
    op(1, 0, 100, 21);
    op(1, 0, 50, 99);
    op(0, 1, 50, 0);          expect_out("rd50", 32'd99, 1'b1);

    op(1, 0, 10, 88);
    op(0, 1, 10, 0);          expect_out("rd10 overwrite", 32'd88, 1'b1);
    op(0, 1, 100, 0);         expect_out("rd100", 32'd21, 1'b1);
    repeat (4) @(negedge clk);
    expect_out("idle hold", 32'd21, 1'b1);

    op(1, 0, 10, 54);
    op(1, 0, 26, 77);
    op(0, 1, 10, 0);          expect_out("rd10 evicted", 32'd54, 1'b0);
    op(0, 1, 26, 0);          expect_out("rd26 miss", 32'd77, 1'b0);
    op(0, 1, 26, 0);          expect_out("rd26 hit", 32'd77, 1'b1);

    op(0, 1, 100, 0);         expect_out("rd100 again", 32'd21, 1'b1);
    op(1, 1, 7, 32'h1234);    expect_out("rd+wr hold", 32'd21, 1'b1);
    op(0, 1, 7, 0);           expect_out("rd7", 32'h1234, 1'b1);

    op(1, 0, 10, 9);
    op(0, 1, 32'h0000_040A, 0); expect_out("upper bits ignored", 32'd9, 1'b1);

    op(1, 0, 3, 5);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 expect_out("async reset", 32'd0, 1'b0);
    #1 rst = 1'b1;
    op(0, 1, 3, 0);           expect_out("rd3 after reset", 32'd5, 1'b0);
    op(0, 1, 100, 0);         expect_out("rd100 after reset", 32'd21, 1'b0);
    op(0, 1, 100, 0);         expect_out("rd100 refilled", 32'd21, 1'b1);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, write-allocate data cache for the MIPS datapath memory stage.
- Contains its own word-addressed backing data memory, so the block is self-contained: a load returns the most recently stored word at that address.
- Single-cycle registered access; no stall handshake. Misses are serviced from the internal memory in the same cycle.

Parameters:
- DATA_W, 32, data word width.
- LINES, 16, number of one-word cache lines (power of 2).
- MEM_WORDS, 1024, backing memory depth in words (power of 2, greater than LINES).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- address  in  32  word address. Only bits [log2(MEM_WORDS)-1:0] are used; upper bits are ignored.
- data_in  in  32  store data.
- write  in  1  store strobe, sampled at posedge.
- read  in  1  load strobe, sampled at posedge.
- temp_out  out  32  registered load data.
- hit  out  1  registered: last read hit the cache.

Behaviour:
- Field split of the word address:
  - index = address[log2(LINES)-1:0]
  - tag = address[log2(MEM_WORDS)-1:log2(LINES)]
  - With defaults: index = [3:0], tag = [9:4].
- Per-line state: valid bit, tag, data word.
- Reset (rst low, asynchronous):
  - All valid bits = 0.
  - temp_out = 0, hit = 0.
  - Backing memory and line data/tag are not reset.
- Write cycle (write=1 at posedge):
  - Memory[address] <= data_in (write-through).
  - Line[index] <= {valid=1, tag, data_in}, overwriting any previous occupant (write-allocate, no dirty state).
  - temp_out and hit hold their values.
- Read cycle (read=1, write=0 at posedge):
  - Hit (valid && tag match): temp_out <= line data; hit <= 1.
  - Miss: temp_out <= Memory[address]; line[index] <= {1, tag, Memory[address]}; hit <= 0.
  - Latency: data is visible on temp_out one clock edge after read is sampled.
- Read and write both high: the write takes priority. temp_out and hit hold; no read is performed.
- Neither strobe high: no state change; temp_out and hit hold indefinitely.
- Conflict: two addresses with the same index and different tags evict each other. Correctness is preserved because the memory always holds current data.
- Reading a never-written memory word returns undefined data; verification must not check this case.
- Reset asserted mid-operation: a pending access is discarded. After release, the first read of any address is a miss, and data comes from memory, which retains the values written before reset.

Decomposition:
- Shared package dcache_pkg:
  - DATA_W, LINES, MEM_WORDS defaults.
  - Derived IDX_W = log2(LINES) and TAG_W = log2(MEM_WORDS) - IDX_W.
  - A typedef for the line record {valid, tag, data}.
- One sub-module dcache_mem: a synchronous-write, combinational-read single-port backing RAM (MEM_WORDS x DATA_W), instantiated once.
- Tag/valid/data arrays and the output registers stay in data_cache.

Test Plan:
- Reset, then write 54@10, 21@100, 99@50, then read 50 -> temp_out = 99 one edge later, hit = 1.
- Write 88@10 (overwrite), then read 10 -> 88, hit = 1; then read 100 -> 21, hit = 1; temp_out holds 21 while read = 0.
- Write 54@10, write 77@26 (same index 10, evicts), read 10 -> miss (hit = 0), temp_out = 54; read 26 -> miss, temp_out = 77; read 26 again -> hit = 1, 77.
- Write 5@3, pulse rst low mid-cycle -> temp_out = 0 and hit = 0 immediately; then read 3 -> hit = 0, temp_out = 5 (memory retained).
- Assert read and write together with data_in = 0x1234 @ 7 while temp_out = 21 -> temp_out stays 21; following read 7 -> 0x1234, hit = 1.
- Address 0x0000_040A (upper bits set) after writing 9@10 -> read returns 9; upper address bits are ignored.
